// File: rtl/sm_seven_seg_capture_if.sv
// Snoop-side view of a multiplexed seven-segment display bus.
// The capture block sits on the slave modport; the display driver or bench uses the master modport.
interface sm_seven_seg_capture_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0]   digit_sel;
    logic [6:0]          seven_segments;
    logic                err_clr;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   err_digit;
    logic                frame_done;

    modport master (
        output digit_sel,
        output seven_segments,
        output err_clr,
        input  value,
        input  valid,
        input  err_digit,
        input  frame_done
    );

    modport slave (
        input  digit_sel,
        input  seven_segments,
        input  err_clr,
        output value,
        output valid,
        output err_digit,
        output frame_done
    );
endinterface

// File: rtl/sm_seven_seg_capture.sv
// Rebuilds the hex word shown on a time-multiplexed seven-segment display.
// A digit commits once its sel/seg pattern has been sampled STABLE_CYCLES times in a row.
//
// state   | meaning
// ST_WAIT | counting identical samples of the current pattern; commit when the run is long enough
// ST_HOLD | current pattern already committed; ignore it until the bus changes
module sm_seven_seg_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_seven_seg_capture_if.slave bus
);
    localparam int              CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t              state_q;
    state_t              state_nxt;

    logic [DIGITS-1:0]   sel_q;
    logic [6:0]          seg_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [4*DIGITS-1:0] value_q;
    logic [4*DIGITS-1:0] value_nxt;
    logic [DIGITS-1:0]   valid_q;
    logic [DIGITS-1:0]   valid_nxt;
    logic [DIGITS-1:0]   err_q;
    logic [DIGITS-1:0]   err_nxt;
    logic [DIGITS-1:0]   seen_q;
    logic [DIGITS-1:0]   seen_nxt;
    logic                frame_q;
    logic                frame_nxt;

    logic                changed;
    logic                sel_onehot;
    logic                commit;
    logic [4:0]          seg_dec;
    logic                seg_legal;
    logic [3:0]          seg_nibble;

    // Returns {legal, nibble}; anything outside the canonical glyph set is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h67:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    assign changed    = {bus.digit_sel, bus.seven_segments} != {sel_q, seg_q};
    assign sel_onehot = $onehot(sel_q);
    assign seg_dec    = seg_decode(seg_q);
    assign seg_legal  = seg_dec[4];
    assign seg_nibble = seg_dec[3:0];

    // Sample register is cleared in reset so the first post-reset pattern always starts a fresh run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            seg_q <= '0;
        end else begin
            sel_q <= bus.digit_sel;
            seg_q <= bus.seven_segments;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (changed) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && !sel_onehot) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        commit    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (sel_onehot && cnt_q == CNT_MAX) begin
                    commit    = 1'b1;
                    state_nxt = changed ? ST_WAIT : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // err_clr is applied first so an illegal commit in the same cycle still sets its bit.
    always_comb begin
        value_nxt = value_q;
        valid_nxt = valid_q;
        err_nxt   = err_q;
        seen_nxt  = seen_q;
        if (bus.err_clr) begin
            err_nxt = '0;
        end
        if (commit) begin
            seen_nxt = seen_q | sel_q;
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_q[i]) begin
                    if (seg_legal) begin
                        value_nxt[4*i +: 4] = seg_nibble;
                        valid_nxt[i]        = 1'b1;
                    end else begin
                        err_nxt[i] = 1'b1;
                    end
                end
            end
        end
        frame_nxt = &seen_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            valid_q <= '0;
            err_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            value_q <= value_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            seen_q  <= frame_nxt ? '0 : seen_nxt;
            frame_q <= frame_nxt;
        end
    end

    assign bus.value      = value_q;
    assign bus.valid      = valid_q;
    assign bus.err_digit  = err_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_sm_seven_seg_capture.sv
// Self-checking bench for sm_seven_seg_capture: a behavioural run-length model predicts
// every cycle's outputs into a queue, which is compared against captured DUT outputs.
module tb_sm_seven_seg_capture;
    localparam int DIGITS = 8;
    localparam int S      = 4;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  valid;
        logic [7:0]  err;
        logic        fd;
    } snap_t;

    logic clk = 1'b0;
    logic rst;

    sm_seven_seg_capture_if #(.DIGITS(DIGITS)) bus ();

    sm_seven_seg_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_cmp = 0;
    int n_bad = 0;

    snap_t exp_q [$];
    snap_t act_q [$];

    // model state
    logic [31:0] m_value = '0;
    logic [7:0]  m_valid = '0;
    logic [7:0]  m_err   = '0;
    logic [7:0]  m_seen  = '0;
    logic        m_fd    = 1'b0;
    bit          run_have = 0;
    bit          run_done = 0;
    int          run_len  = 0;
    logic [7:0]  run_sel  = '0;
    logic [6:0]  run_seg  = '0;

    // Drive one clock of stimulus, predict the outputs after that edge, capture the DUT's.
    task automatic step(input logic [7:0] sel, input logic [6:0] seg, input logic clr, input logic r);
        bit         commit;
        bit         legal;
        logic [3:0] nib;
        bus.digit_sel      = sel;
        bus.seven_segments = seg;
        bus.err_clr        = clr;
        rst                = r;
        if (r) begin
            m_value = '0; m_valid = '0; m_err = '0; m_seen = '0; m_fd = 1'b0;
            run_have = 0; run_done = 0; run_len = 0;
        end else begin
            m_fd   = 1'b0;
            commit = run_have && run_len >= S && !run_done && $onehot(run_sel);
            if (clr) m_err = '0;
            if (commit) begin
                run_done = 1;
                legal    = 0;
                nib      = '0;
                for (int k = 0; k < 16; k++)
                    if (seg_tab[k] == run_seg) begin legal = 1; nib = 4'(k); end
                for (int i = 0; i < DIGITS; i++) begin
                    if (run_sel[i]) begin
                        if (legal) begin m_value[4*i +: 4] = nib; m_valid[i] = 1'b1; end
                        else m_err[i] = 1'b1;
                    end
                end
                m_seen = m_seen | run_sel;
                if (&m_seen) begin m_fd = 1'b1; m_seen = '0; end
            end
            if (run_have && sel == run_sel && seg == run_seg) begin
                run_len++;
            end else begin
                run_have = 1; run_done = 0; run_len = 1; run_sel = sel; run_seg = seg;
            end
        end
        exp_q.push_back({m_value, m_valid, m_err, m_fd});
        @(posedge clk);
        #1;
        act_q.push_back({bus.value, bus.valid, bus.err_digit, bus.frame_done});
    endtask

    task automatic test_reset();
        snap_t e, a;
        for (int i = 0; i < 3; i++)
            step(8'($urandom), 7'($urandom), 1'($urandom), 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL reset: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
        end
    endtask

    task automatic test_commit();
        snap_t e, a;
        step(8'h00, 7'h00, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h01, 7'h4F, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.value[3:0] !== 4'h3 || bus.valid !== 8'h01) begin
            n_bad++;
            $display("FAIL commit_latency: got nibble0=%h valid=%h, want 3 / 01", bus.value[3:0], bus.valid);
        end
        for (int i = 0; i < 3; i++) step(8'h02, 7'h06, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.valid !== 8'h01 || bus.value !== 32'h0000_0003) begin
            n_bad++;
            $display("FAIL short_run: got value=%h valid=%h, want 00000003 / 01", bus.value, bus.valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL commit: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
        end
    endtask

    task automatic test_illegal_clear();
        snap_t e, a;
        for (int i = 0; i < 4; i++) step(8'h04, 7'h6F, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err_digit !== 8'h04 || bus.value[11:8] !== 4'h0 || bus.valid[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal: got err=%h nibble2=%h valid2=%b, want 04 / 0 / 0",
                     bus.err_digit, bus.value[11:8], bus.valid[2]);
        end
        step(8'h00, 7'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.err_digit !== 8'h00) begin
            n_bad++;
            $display("FAIL err_clr: got err=%h, want 00", bus.err_digit);
        end
        for (int i = 0; i < 4; i++) step(8'h02, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h04, 7'h6F, 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.err_digit !== 8'h04) begin
            n_bad++;
            $display("FAIL clr_vs_commit: got err=%h, want 04", bus.err_digit);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL illegal_seq: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
        end
    endtask

    task automatic test_full_scan();
        snap_t e, a;
        int    idx = 0;
        int    fd_cnt = 0;
        int    fd_at = -1;
        step(8'h00, 7'h00, 1'b0, 1'b1);
        step(8'h00, 7'h00, 1'b0, 1'b1);
        for (int d = 0; d < DIGITS; d++)
            for (int c = 0; c < 6; c++) step(8'(1 << d), seg_tab[d+1], 1'b0, 1'b0);
        step(8'h00, 7'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.value !== 32'h8765_4321 || bus.valid !== 8'hFF || bus.err_digit !== 8'h00) begin
            n_bad++;
            $display("FAIL full_scan_word: got value=%h valid=%h err=%h, want 87654321 / ff / 00",
                     bus.value, bus.valid, bus.err_digit);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a.fd === 1'b1) begin fd_cnt++; fd_at = idx; end
            if (a !== e) begin
                n_bad++;
                $display("FAIL full_scan[%0d]: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         idx, a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
            idx++;
        end
        n_cmp++;
        if (fd_cnt != 1 || fd_at != 2 + 7*6 + S) begin
            n_bad++;
            $display("FAIL frame_done: got %0d pulses at step %0d, want 1 pulse at step %0d", fd_cnt, fd_at, 2 + 7*6 + S);
        end
    endtask

    task automatic test_filtering();
        snap_t e, a;
        for (int i = 0; i < 10; i++) step(8'h03, 7'h06, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(8'h00, 7'h06, 1'b0, 1'b0);
        n_cmp++;
        if (bus.value !== 32'h8765_4321 || bus.valid !== 8'hFF || bus.err_digit !== 8'h00) begin
            n_bad++;
            $display("FAIL bad_sel: got value=%h valid=%h err=%h, want 87654321 / ff / 00",
                     bus.value, bus.valid, bus.err_digit);
        end
        for (int i = 0; i < 3; i++) step(8'h08, 7'h5B, 1'b0, 1'b0);
        step(8'h08, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h08, 7'h5B, 1'b0, 1'b0);
        n_cmp++;
        if (bus.value[15:12] !== 4'h4) begin
            n_bad++;
            $display("FAIL glitch_early: got nibble3=%h, want 4", bus.value[15:12]);
        end
        step(8'h08, 7'h5B, 1'b0, 1'b0);
        n_cmp++;
        if (bus.value[15:12] !== 4'h2) begin
            n_bad++;
            $display("FAIL glitch_commit: got nibble3=%h, want 2", bus.value[15:12]);
        end
        step(8'h00, 7'h00, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL filtering: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t e, a;
        for (int i = 0; i < 3; i++) step(8'h20, 7'h7D, 1'b0, 1'b0);
        step(8'h20, 7'h7D, 1'b0, 1'b1);
        n_cmp++;
        if (bus.value !== 32'h0 || bus.valid !== 8'h00 || bus.err_digit !== 8'h00 || bus.frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got value=%h valid=%h err=%h fd=%b, want all zero",
                     bus.value, bus.valid, bus.err_digit, bus.frame_done);
        end
        for (int i = 0; i < 4; i++) step(8'h20, 7'h7D, 1'b0, 1'b0);
        n_cmp++;
        if (bus.valid !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_early: got valid=%h, want 00", bus.valid);
        end
        step(8'h20, 7'h7D, 1'b0, 1'b0);
        n_cmp++;
        if (bus.valid !== 8'h20 || bus.value !== 32'h0060_0000) begin
            n_bad++;
            $display("FAIL post_reset_commit: got value=%h valid=%h, want 00600000 / 20", bus.value, bus.valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL reset_mid_run: got value=%h valid=%h err=%h fd=%b, want value=%h valid=%h err=%h fd=%b",
                         a.value, a.valid, a.err, a.fd, e.value, e.valid, e.err, e.fd);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.digit_sel      = '0;
        bus.seven_segments = '0;
        bus.err_clr        = 1'b0;
        #2;
        test_reset();
        test_commit();
        test_illegal_clear();
        test_full_scan();
        test_filtering();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
